// File: rtl/immediate_formatter.sv
`default_nettype none
// ============================================================================
// Module      : immediate_formatter
// Description : Streams a 32-bit immediate as ASCII "0x" + hex digits +
//               delimiter, one character per valid/ready handshake, MSB-first.
//               Feeds a UART/console/listing path so assembled immediates can
//               be echoed back.
// Ports       : clk_in       - system clock
//               rst_in       - synchronous active-high reset
//               start        - format request, accepted only in IDLE
//               immediate    - value to format, latched on accepted start
//               delim_comma  - latched with start; 1 -> ",", 0 -> " "
//               busy         - high from PFX0 through RETURN
//               char_valid   - char_out holds a character to transfer
//               char_ready   - downstream accepts char_out this cycle
//               char_out     - ASCII character
//               done_flag    - one-cycle pulse after the delimiter transfer
// Parameters  : NUM_DIGITS (1..8) digits emitted from the low 4*NUM_DIGITS bits
//               UPPERCASE  1 -> 'A'-'F' and 'X', 0 -> 'a'-'f' and 'x'
// Options     : LEADING_ZERO_SUPPRESS_EN - when defined, leading zero digits
//               are skipped (a zero value still emits a single "0").
// Revision    : 1.0 - initial release
// ============================================================================
module immediate_formatter #(
  parameter int NUM_DIGITS = 8,
  parameter int UPPERCASE  = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [31:0] immediate,
  input  logic        delim_comma,
  output logic        busy,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_out,
  output logic        done_flag
);

  localparam logic [2:0] C_LAST_DIGIT = 3'(NUM_DIGITS - 1);
  // Offset added to nibbles 10..15 so that 10 lands on 'A'/'a'.
  localparam logic [7:0] C_ALPHA_BASE = (UPPERCASE != 0) ? 8'h37 : 8'h57;
  localparam logic [7:0] C_PREFIX_X   = (UPPERCASE != 0) ? 8'h58 : 8'h78;
  localparam logic [7:0] C_CHAR_ZERO  = 8'h30;
  localparam logic [7:0] C_COMMA      = 8'h2C;
  localparam logic [7:0] C_SPACE      = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PFX0   = 3'd1,
    S_PFX1   = 3'd2,
    S_DIGIT  = 3'd3,
    S_DELIM  = 3'd4,
    S_RETURN = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_value;
  logic [31:0] w_value_nxt;
  logic        r_delim;
  logic        w_delim_nxt;
  logic [2:0]  r_count;
  logic [2:0]  w_count_nxt;
  logic [2:0]  w_start_count;
  logic [7:0]  r_char;
  logic [7:0]  w_char_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_busy;
  logic        r_done;
  logic        w_xfer;

  assign w_xfer = r_valid && char_ready;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return C_CHAR_ZERO + {4'h0, nib};
    end
    return C_ALPHA_BASE + {4'h0, nib};
  endfunction

  // Digit index the DIGIT state starts from; resolved at start acceptance so
  // the prefix characters hide the search and latency does not change.
`ifdef LEADING_ZERO_SUPPRESS_EN
  always_comb begin
    w_start_count = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (immediate[4*i +: 4] != 4'h0) begin
        w_start_count = 3'(i);
      end
    end
  end
`else
  assign w_start_count = C_LAST_DIGIT;
`endif

  // Next-state logic. Without a transfer every register holds, which keeps
  // char_out stable under backpressure.
  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_delim_nxt = r_delim;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_value_nxt = immediate;
          w_delim_nxt = delim_comma;
          w_count_nxt = w_start_count;
          w_state_nxt = S_PFX0;
        end
      end
      S_PFX0: begin
        if (w_xfer) w_state_nxt = S_PFX1;
      end
      S_PFX1: begin
        if (w_xfer) w_state_nxt = S_DIGIT;
      end
      S_DIGIT: begin
        if (w_xfer) begin
          if (r_count == 3'd0) begin
            w_state_nxt = S_DELIM;
          end else begin
            w_count_nxt = r_count - 3'd1;
          end
        end
      end
      S_DELIM: begin
        if (w_xfer) w_state_nxt = S_RETURN;
      end
      S_RETURN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the outputs leave the flops
  // aligned with the state they describe.
  always_comb begin
    w_char_nxt  = 8'h00;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_PFX0: begin
        w_char_nxt  = C_CHAR_ZERO;
        w_valid_nxt = 1'b1;
      end
      S_PFX1: begin
        w_char_nxt  = C_PREFIX_X;
        w_valid_nxt = 1'b1;
      end
      S_DIGIT: begin
        w_char_nxt  = hex_ascii(w_value_nxt[{w_count_nxt, 2'b00} +: 4]);
        w_valid_nxt = 1'b1;
      end
      S_DELIM: begin
        w_char_nxt  = w_delim_nxt ? C_COMMA : C_SPACE;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_char_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_value <= 32'h0;
      r_delim <= 1'b0;
      r_count <= 3'd0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_delim <= w_delim_nxt;
      r_count <= w_count_nxt;
      r_char  <= w_char_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_RETURN);
    end
  end

  assign busy       = r_busy;
  assign char_valid = r_valid;
  assign char_out   = r_char;
  assign done_flag  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_immediate_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_immediate_formatter
// Description : Self-checking bench for immediate_formatter. Three instances
//               share stimulus: A (8 digits, lower case), B (8 digits, upper
//               case) and C (2 digits, lower case). A vector table covers the
//               main function; hand-written sequences cover restart-while-busy,
//               start during RETURN and reset mid-stream. Expected streams
//               follow LEADING_ZERO_SUPPRESS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_immediate_formatter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start;
  logic [31:0] immediate;
  logic        delim_comma;
  logic        char_ready;

  logic       a_busy, a_valid, a_done;
  logic [7:0] a_char;
  logic       b_busy, b_valid, b_done;
  logic [7:0] b_char;
  logic       c_busy, c_valid, c_done;
  logic [7:0] c_char;

  always #5 clk_in = ~clk_in;

  immediate_formatter #(.NUM_DIGITS(8), .UPPERCASE(0)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .immediate(immediate),
    .delim_comma(delim_comma), .busy(a_busy), .char_valid(a_valid),
    .char_ready(char_ready), .char_out(a_char), .done_flag(a_done)
  );

  immediate_formatter #(.NUM_DIGITS(8), .UPPERCASE(1)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .immediate(immediate),
    .delim_comma(delim_comma), .busy(b_busy), .char_valid(b_valid),
    .char_ready(char_ready), .char_out(b_char), .done_flag(b_done)
  );

  immediate_formatter #(.NUM_DIGITS(2), .UPPERCASE(0)) u_dut_c (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .immediate(immediate),
    .delim_comma(delim_comma), .busy(c_busy), .char_valid(c_valid),
    .char_ready(char_ready), .char_out(c_char), .done_flag(c_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  string qa, qb, qc;
  int    a_dn, b_dn, c_dn;
  int    a_last_x, a_done_cyc;
  bit    a_hold_prev;
  logic [7:0] a_hold_char;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_s(input string name, input string got, input string exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
    end
  endtask

  always @(posedge clk_in) cyc++;

  // Transfer monitors, sampled on the falling edge where inputs and
  // registered outputs are both settled.
  always @(negedge clk_in) begin
    if (a_hold_prev) begin
      chk("hold_valid", {31'h0, a_valid}, 32'h1);
      chk("hold_char", {24'h0, a_char}, {24'h0, a_hold_char});
    end
    a_hold_prev = a_valid && !char_ready && !rst_in;
    a_hold_char = a_char;
    if (a_valid && char_ready && !rst_in) begin
      qa = {qa, $sformatf("%c", a_char)};
      a_last_x = cyc;
    end
    if (a_done) begin
      a_dn++;
      a_done_cyc = cyc;
    end
  end

  always @(negedge clk_in) begin
    if (b_valid && char_ready && !rst_in) qb = {qb, $sformatf("%c", b_char)};
    if (c_valid && char_ready && !rst_in) qc = {qc, $sformatf("%c", c_char)};
    if (b_done) b_dn++;
    if (c_done) c_dn++;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear();
    qa = ""; qb = ""; qc = "";
    a_dn = 0; b_dn = 0; c_dn = 0;
    a_last_x = -1; a_done_cyc = -1;
  endtask

  // Runs until every instance has pulsed done_flag; bp selects the
  // 1,0,0,1 ready pattern instead of ready tied high.
  task automatic wait_all_done(input string name, input bit bp);
    int n = 0;
    while (!(a_dn > 0 && b_dn > 0 && c_dn > 0) && n < 300) begin
      char_ready = bp ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
      step();
      n++;
    end
    char_ready = 1'b1;
    chk({name, "_done_seen"}, {31'h0, (a_dn > 0 && b_dn > 0 && c_dn > 0)}, 32'h1);
  endtask

  task automatic pulse_start(input logic [31:0] imm, input logic comma);
    immediate   = imm;
    delim_comma = comma;
    char_ready  = 1'b1;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  typedef struct {
    logic [31:0] imm;
    logic        comma;
    bit          bp;
    string       ea;
    string       eb;
    string       ec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'hDEADBEEF, 1'b0, 1'b0, "0xdeadbeef ", "0XDEADBEEF ", "0xef "};
    vecs[1] = '{32'h1234_5F7C, 1'b0, 1'b0, "0x12345f7c ", "0X12345F7C ", "0x7c "};
`ifdef LEADING_ZERO_SUPPRESS_EN
    vecs[2] = '{32'h0000_00A5, 1'b1, 1'b0, "0xa5,", "0XA5,", "0xa5,"};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, "0x0 ", "0X0 ", "0x0 "};
    vecs[4] = '{32'h0000_0100, 1'b1, 1'b0, "0x100,", "0X100,", "0x0,"};
`else
    vecs[2] = '{32'h0000_00A5, 1'b1, 1'b0, "0x000000a5,", "0X000000A5,", "0xa5,"};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b0, "0x00000000 ", "0X00000000 ", "0x00 "};
    vecs[4] = '{32'h0000_0100, 1'b1, 1'b0, "0x00000100,", "0X00000100,", "0x00,"};
`endif
    vecs[5] = '{32'hDEADBEEF, 1'b0, 1'b1, "0xdeadbeef ", "0XDEADBEEF ", "0xef "};

    a_hold_prev = 1'b0;
    clear();
    rst_in = 1'b1; start = 1'b0; immediate = 32'h0; delim_comma = 1'b0; char_ready = 1'b1;
    repeat (3) step();
    @(negedge clk_in);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_char", {24'h0, a_char}, 32'h0);
    chk("rst_done", {31'h0, a_done}, 32'h0);
    chk("rst_b_valid", {31'h0, b_valid}, 32'h0);
    chk("rst_c_busy", {31'h0, c_busy}, 32'h0);
    step();
    rst_in = 1'b0;
    step();

    // Table-driven streams
    for (int i = 0; i < 6; i++) begin
      clear();
      pulse_start(vecs[i].imm, vecs[i].comma);
      @(negedge clk_in);
      chk($sformatf("v%0d_latency_valid", i), {31'h0, a_valid}, 32'h1);
      chk($sformatf("v%0d_latency_busy", i), {31'h0, a_busy}, 32'h1);
      chk($sformatf("v%0d_first_char", i), {24'h0, a_char}, 32'h30);
      wait_all_done($sformatf("v%0d", i), vecs[i].bp);
      step();
      step();
      chk_s($sformatf("v%0d_stream_a", i), qa, vecs[i].ea);
      chk_s($sformatf("v%0d_stream_b", i), qb, vecs[i].eb);
      chk_s($sformatf("v%0d_stream_c", i), qc, vecs[i].ec);
      chk($sformatf("v%0d_done_count", i), a_dn, 32'd1);
      chk($sformatf("v%0d_done_after_delim", i), a_done_cyc, a_last_x + 1);
      chk($sformatf("v%0d_idle_busy", i), {31'h0, a_busy}, 32'h0);
    end

    // Restart while busy is ignored; next start in IDLE is accepted
    clear();
    pulse_start(32'hDEADBEEF, 1'b0);
    step();
    step();
    pulse_start(32'h1234_5678, 1'b1);
    wait_all_done("restart", 1'b0);
    step();
    step();
    chk_s("restart_ignored", qa, "0xdeadbeef ");
    clear();
    pulse_start(32'h1234_5678, 1'b1);
    // Start asserted during the RETURN cycle must not be accepted
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_in);
      if (a_done) break;
    end
    chk("return_reached", {31'h0, a_done}, 32'h1);
    start = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    @(negedge clk_in);
    chk("return_start_busy", {31'h0, a_busy}, 32'h0);
    chk("return_start_valid", {31'h0, a_valid}, 32'h0);
    repeat (20) step();
`ifdef LEADING_ZERO_SUPPRESS_EN
    chk_s("accept_after_idle", qa, "0x12345678,");
`else
    chk_s("accept_after_idle", qa, "0x12345678,");
`endif
    chk("return_single_done", a_dn, 32'd1);

    // Reset after the 4th transfer aborts the stream
    clear();
    pulse_start(32'hDEADBEEF, 1'b0);
    for (int n = 0; n < 50 && qa.len() < 4; n++) step();
    rst_in = 1'b1;
    step();
    @(negedge clk_in);
    chk("midrst_valid", {31'h0, a_valid}, 32'h0);
    chk("midrst_busy", {31'h0, a_busy}, 32'h0);
    chk("midrst_char", {24'h0, a_char}, 32'h0);
    step();
    rst_in = 1'b0;
    repeat (20) step();
    chk("midrst_no_done", a_dn, 32'd0);
    chk_s("midrst_partial", qa, "0xde");
    clear();
    pulse_start(32'hDEADBEEF, 1'b0);
    wait_all_done("post_rst", 1'b0);
    step();
    chk_s("post_rst_stream", qa, "0xdeadbeef ");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
